// File: rtl/pin_guard.sv
// pin_guard
//
// Purpose:
//   Consumes the per-attempt verdict of the PIN entry block. It counts
//   consecutive failed attempts and holds the wallet lock state. Every
//   LOCK_FAILS failures it imposes a timed lockout. When the count reaches
//   WIPE_FAILS it issues a one-shot erase command and parks in a terminal
//   wiped state until reset. Every output comes straight from a flop.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset, overrides every other input
//   done_i      one-cycle pulse, a 4-digit attempt has completed
//   match_i     attempt verdict, meaningful only while done_i=1
//   lock_req_i  request to re-lock an unlocked wallet
//   unlock_o    level, wallet unlocked
//   lockout_o   level, lockout timer running and attempts refused
//   wiped_o     level, terminal wiped state
//   wipe_o      one-cycle pulse, erase command to key storage
//   reject_o    one-cycle pulse, an attempt arrived while not accepted
//   fail_cnt_o  current consecutive failure count, saturating at WIPE_FAILS

module pin_guard #(
  parameter int LOCK_FAILS  = 3,
  parameter int WIPE_FAILS  = 9,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                done_i,
  input  logic                                match_i,
  input  logic                                lock_req_i,
  output logic                                unlock_o,
  output logic                                lockout_o,
  output logic                                wiped_o,
  output logic                                wipe_o,
  output logic                                reject_o,
  output logic [$clog2(WIPE_FAILS+1)-1:0]     fail_cnt_o
);

  localparam int CNT_W = $clog2(WIPE_FAILS + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] WIPE_N   = CNT_W'(WIPE_FAILS);
  localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_FAILS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_UNLOCKED,
    ST_LOCKOUT,
    ST_WIPED
  } state_t;

  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             wipe_next;
  logic             reject_next;

  // The count can never pass WIPE_FAILS because reaching it ends in the
  // wiped state. The clamp keeps it from wrapping even if that ever changes.
  assign cnt_inc = (fail_cnt_o == WIPE_N) ? WIPE_N : fail_cnt_o + CNT_W'(1);

  // Next-state logic. Reaching the wipe threshold takes priority over the
  // lockout trigger, even when the count is also a multiple of LOCK_FAILS.
  // The lockout timer is loaded with the full duration on entry. Lockout
  // ends on the cycle in which the timer would count down to zero, so
  // lockout_o stays high for exactly LOCK_CYCLES cycles.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    cnt_next    = fail_cnt_o;
    wipe_next   = 1'b0;
    reject_next = 1'b0;

    case (state)
      ST_LOCKED: begin
        if (done_i) begin
          if (match_i) begin
            state_next = ST_UNLOCKED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc == WIPE_N) begin
              state_next = ST_WIPED;
              wipe_next  = 1'b1;
            end else if ((cnt_inc % LOCK_N) == '0) begin
              state_next = ST_LOCKOUT;
              timer_next = TMR_LOAD;
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (lock_req_i) begin
          state_next = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        if (done_i) begin
          reject_next = 1'b1;
        end
        if (timer <= TMR_W'(1)) begin
          state_next = ST_LOCKED;
          timer_next = '0;
        end else begin
          timer_next = timer - TMR_W'(1);
        end
      end

      ST_WIPED: begin
        if (done_i) begin
          reject_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_LOCKED;
        timer_next = '0;
      end
    endcase
  end

  // State, timer and output registers. The level outputs are registered
  // decodes of the next state, so they line up with the state register
  // and no input can reach an output combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_LOCKED;
      timer      <= '0;
      fail_cnt_o <= '0;
      unlock_o   <= 1'b0;
      lockout_o  <= 1'b0;
      wiped_o    <= 1'b0;
      wipe_o     <= 1'b0;
      reject_o   <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      fail_cnt_o <= cnt_next;
      unlock_o   <= (state_next == ST_UNLOCKED);
      lockout_o  <= (state_next == ST_LOCKOUT);
      wiped_o    <= (state_next == ST_WIPED);
      wipe_o     <= wipe_next;
      reject_o   <= reject_next;
    end
  end

endmodule

// File: tb/tb_pin_guard.sv
// tb_pin_guard
//
// Purpose:
//   Directed self-checking bench for pin_guard, with LOCK_FAILS=3,
//   WIPE_FAILS=6 and LOCK_CYCLES=8. A table of single-cycle vectors covers
//   reset, unlocking and re-locking. Hand-written sequences cover lockout,
//   wipe and reset during lockout.
//
// Ports: none (top-level bench).

module tb_pin_guard;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_UNL  = 5'b10000;
  localparam logic [4:0] F_LKO  = 5'b01000;
  localparam logic [4:0] F_WPD  = 5'b00100;
  localparam logic [4:0] F_WIPE = 5'b00010;
  localparam logic [4:0] F_REJ  = 5'b00001;

  typedef struct {
    logic       rst;
    logic       done;
    logic       match;
    logic       lock;
    logic [4:0] exp_flags;
    logic [2:0] exp_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       done_i = 1'b0;
  logic       match_i = 1'b0;
  logic       lock_req_i = 1'b0;
  logic       unlock_o;
  logic       lockout_o;
  logic       wiped_o;
  logic       wipe_o;
  logic       reject_o;
  logic [2:0] fail_cnt_o;

  int   checks = 0;
  int   passes = 0;
  vec_t vecs[$];

  pin_guard #(
    .LOCK_FAILS (3),
    .WIPE_FAILS (6),
    .LOCK_CYCLES(8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .done_i    (done_i),
    .match_i   (match_i),
    .lock_req_i(lock_req_i),
    .unlock_o  (unlock_o),
    .lockout_o (lockout_o),
    .wiped_o   (wiped_o),
    .wipe_o    (wipe_o),
    .reject_o  (reject_o),
    .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the rising edge so that the
  // outputs settle before they are sampled.
  task automatic applyStimulus(input logic rst, input logic done,
                               input logic match, input logic lock);
    rst_i      = rst;
    done_i     = done;
    match_i    = match;
    lock_req_i = lock;
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against the expected flags {unlock, lockout, wiped,
  // wipe, reject} and the expected failure count.
  task automatic checkOutput(input string name, input logic [4:0] exp_flags,
                             input logic [2:0] exp_cnt);
    logic [4:0] got;
    got = {unlock_o, lockout_o, wiped_o, wipe_o, reject_o};
    checks++;
    if (got !== exp_flags || fail_cnt_o !== exp_cnt) begin
      $display("[TB] FAIL %s: got flags=%b cnt=%0d, required flags=%b cnt=%0d",
               name, got, fail_cnt_o, exp_flags, exp_cnt);
    end else begin
      passes++;
    end
  endtask

  task automatic add_vec(input logic rst, input logic done, input logic match,
                         input logic lock, input logic [4:0] flags,
                         input logic [2:0] cnt);
    vec_t v;
    v.rst       = rst;
    v.done      = done;
    v.match     = match;
    v.lock      = lock;
    v.exp_flags = flags;
    v.exp_cnt   = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset held with an attempt pending, then release.
    add_vec(1, 1, 1, 0, F_NONE, 3'd0);
    add_vec(1, 1, 1, 0, F_NONE, 3'd0);
    add_vec(0, 0, 0, 0, F_NONE, 3'd0);
    // Match unlocks, then lock request beats a simultaneous attempt.
    add_vec(0, 1, 1, 0, F_UNL,  3'd0);
    add_vec(0, 1, 0, 1, F_NONE, 3'd0);
    add_vec(0, 0, 0, 0, F_NONE, 3'd0);
    // match without done is ignored.
    add_vec(0, 0, 1, 0, F_NONE, 3'd0);
    // Two fails then a match: count clears, no lockout.
    add_vec(0, 1, 0, 0, F_NONE, 3'd1);
    add_vec(0, 0, 0, 0, F_NONE, 3'd1);
    add_vec(0, 1, 0, 0, F_NONE, 3'd2);
    add_vec(0, 1, 1, 0, F_UNL,  3'd0);
    // Attempts while unlocked are ignored.
    add_vec(0, 1, 0, 0, F_UNL,  3'd0);
    add_vec(0, 0, 0, 1, F_NONE, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].done, vecs[i].match, vecs[i].lock);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_flags, vecs[i].exp_cnt);
    end

    // Three fails lead to an 8-cycle lockout. An attempt in lockout cycle 4
    // gives a reject in cycle 5. A lock request in cycle 6 is ignored.
    applyStimulus(0, 1, 0, 0);
    checkOutput("lk_fail1", F_NONE, 3'd1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("lk_fail2", F_NONE, 3'd2);
    applyStimulus(0, 1, 0, 0);
    checkOutput("lk_cycle1", F_LKO, 3'd3);
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(0, (k == 5), 1'b1, (k == 7));
      checkOutput($sformatf("lk_cycle%0d", k),
                  (k == 5) ? (F_LKO | F_REJ) : F_LKO, 3'd3);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("lk_expired", F_NONE, 3'd3);

    // Three more fails: the sixth wipes, even though it is a multiple of 3.
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_fail4", F_NONE, 3'd4);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_fail5", F_NONE, 3'd5);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_wipe", F_WPD | F_WIPE, 3'd6);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wp_hold", F_WPD, 3'd6);
    applyStimulus(0, 1, 1, 0);
    checkOutput("wp_reject", F_WPD | F_REJ, 3'd6);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wp_lockreq", F_WPD, 3'd6);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wp_reject2", F_WPD | F_REJ, 3'd6);
    applyStimulus(1, 0, 0, 0);
    checkOutput("wp_reset", F_NONE, 3'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wp_after_reset", F_NONE, 3'd0);

    // Reset in lockout cycle 4 clears everything. A single fail afterwards
    // counts from 1 and does not lock out.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rl_cycle1", F_LKO, 3'd3);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("rl_cycle%0d", k), F_LKO, 3'd3);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("rl_reset", F_NONE, 3'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rl_fail1", F_NONE, 3'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rl_idle", F_NONE, 3'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
